// File: rtl/sfpp_reconfig_st_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sfpp_reconfig_st_arbiter_if
// Description : Two non-backpressurable ST sources, one shared ST sink,
//               plus grant/overflow status for the reconfig arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface sfpp_reconfig_st_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              in0_valid;
    logic [DATA_W-1:0] in0_data;
    logic              in0_sop;
    logic              in0_eop;
    logic              in1_valid;
    logic [DATA_W-1:0] in1_data;
    logic              in1_sop;
    logic              in1_eop;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_ready;
    logic [1:0]        grant;
    logic [1:0]        ovf;
    logic [1:0]        ovf_clr;

    modport master (
        output in0_valid, in0_data, in0_sop, in0_eop,
        output in1_valid, in1_data, in1_sop, in1_eop,
        output out_ready, ovf_clr,
        input  out_valid, out_data, out_sop, out_eop, grant, ovf
    );

    modport slave (
        input  in0_valid, in0_data, in0_sop, in0_eop,
        input  in1_valid, in1_data, in1_sop, in1_eop,
        input  out_ready, ovf_clr,
        output out_valid, out_data, out_sop, out_eop, grant, ovf
    );
endinterface
`default_nettype wire

// File: rtl/sfpp_reconfig_st_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sfpp_reconfig_st_arbiter
// Description : Two FWFT input FIFOs feeding a packet-locked round-robin
//               arbiter onto one Avalon-ST reconfig sink; drops are flagged.
// Revision    : 1.0 - initial release
// ============================================================================
module sfpp_reconfig_st_arbiter #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    sfpp_reconfig_st_arbiter_if.slave st
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = DATA_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_G0   = 2'd1,
        S_G1   = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last_grant;
    logic [1:0] r_grant;
    logic [1:0] r_ovf;

    logic [1:0] w_in_valid;
    logic [1:0][c_ENT_W-1:0] w_in_ent;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_drop;
    logic [1:0] w_nempty;
    logic [1:0] w_full;
    logic [1:0] w_head_sop;
    logic [1:0] w_head_eop;
    logic [1:0][DATA_W-1:0] w_head_data;
    logic [1:0] w_cand;
    logic       w_out_valid;
    logic       w_sel;

    assign w_in_valid  = {st.in1_valid, st.in0_valid};
    assign w_in_ent[0] = {st.in0_sop, st.in0_eop, st.in0_data};
    assign w_in_ent[1] = {st.in1_sop, st.in1_eop, st.in1_data};

    for (genvar i = 0; i < 2; i++) begin : g_fifo
        logic [c_ENT_W-1:0] r_mem [FIFO_DEPTH];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [c_CNT_W-1:0] r_count;
        logic [c_ENT_W-1:0] w_head;

        assign w_head         = r_mem[r_rptr];
        assign w_nempty[i]    = (r_count != '0);
        assign w_full[i]      = (r_count == c_CNT_W'(FIFO_DEPTH));
        // A full FIFO still accepts a beat when its head leaves in the same cycle
        assign w_push[i]      = w_in_valid[i] & (~w_full[i] | w_pop[i]);
        assign w_drop[i]      = w_in_valid[i] & w_full[i] & ~w_pop[i];
        assign w_head_sop[i]  = w_head[c_ENT_W-1];
        assign w_head_eop[i]  = w_head[c_ENT_W-2];
        assign w_head_data[i] = w_head[DATA_W-1:0];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push[i]) begin
                    r_mem[r_wptr] <= w_in_ent[i];
                    r_wptr        <= r_wptr + c_PTR_W'(1);
                end
                if (w_pop[i]) begin
                    r_rptr <= r_rptr + c_PTR_W'(1);
                end
                if (w_push[i] != w_pop[i]) begin
                    r_count <= w_push[i] ? r_count + c_CNT_W'(1) : r_count - c_CNT_W'(1);
                end
            end
        end
    end

    // In IDLE any head without sop is an orphan and is discarded
    always_comb begin
        w_pop = 2'b00;
        case (r_state)
            S_IDLE:  w_pop    = w_nempty & ~w_head_sop;
            S_G0:    w_pop[0] = w_nempty[0] & st.out_ready;
            S_G1:    w_pop[1] = w_nempty[1] & st.out_ready;
            default: w_pop    = 2'b00;
        endcase
    end

    assign w_cand = w_nempty & w_head_sop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cand[0] && (!w_cand[1] || r_last_grant)) begin
                        r_state      <= S_G0;
                        r_last_grant <= 1'b0;
                        r_grant      <= 2'b01;
                    end else if (w_cand[1]) begin
                        r_state      <= S_G1;
                        r_last_grant <= 1'b1;
                        r_grant      <= 2'b10;
                    end
                end
                S_G0: begin
                    if (w_pop[0] && w_head_eop[0]) begin
                        r_state <= S_IDLE;
                        r_grant <= 2'b00;
                    end
                end
                S_G1: begin
                    if (w_pop[1] && w_head_eop[1]) begin
                        r_state <= S_IDLE;
                        r_grant <= 2'b00;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 2'b00;
        end else begin
            r_ovf <= w_drop | (r_ovf & ~st.ovf_clr);
        end
    end

    assign w_sel       = (r_state == S_G1);
    assign w_out_valid = ((r_state == S_G0) & w_nempty[0]) |
                         ((r_state == S_G1) & w_nempty[1]);

    assign st.out_valid = w_out_valid;
    assign st.out_data  = w_out_valid ? w_head_data[w_sel] : '0;
    assign st.out_sop   = w_out_valid & w_head_sop[w_sel];
    assign st.out_eop   = w_out_valid & w_head_eop[w_sel];
    assign st.grant     = r_grant;
    assign st.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sfpp_reconfig_st_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sfpp_reconfig_st_arbiter
// Description : Directed self-checking bench for the reconfig ST arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfpp_reconfig_st_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    sfpp_reconfig_st_arbiter_if #(.DATA_W(8)) bus ();

    sfpp_reconfig_st_arbiter #(
        .DATA_W     (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .st    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {valid, sop, eop, data}
    function automatic logic [10:0] beat(input logic s, input logic e, input logic [7:0] d);
        return {1'b1, s, e, d};
    endfunction

    // {ovf, out_valid, out_sop, out_eop, grant, out_data}
    function automatic logic [14:0] xp(input logic [1:0] o, input logic v, input logic s,
                                       input logic e, input logic [1:0] g, input logic [7:0] d);
        return {o, v, s, e, g, d};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.ovf, bus.out_valid, bus.out_sop, bus.out_eop, bus.grant, bus.out_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [10:0] a0, input logic [10:0] a1,
                         input logic r, input logic [1:0] c);
        {bus.in0_valid, bus.in0_sop, bus.in0_eop, bus.in0_data} = a0;
        {bus.in1_valid, bus.in1_sop, bus.in1_eop, bus.in1_data} = a1;
        bus.out_ready = r;
        bus.ovf_clr   = c;
    endtask

    task automatic test_reset();
        logic [10:0] s0 [8] = '{default: '0};
        logic [14:0] ex [8] = '{default: '0};
        reset = 1'b1;
        apply('0, '0, 1'b1, 2'b11);
        step();
        @(negedge clk);
        checks++;
        if (obs() !== 15'h0) begin
            failures++;
            $display("FAIL reset_state: got %h required %h", obs(), 15'h0);
        end
        step();
        reset = 1'b0;
        s0[0] = beat(1, 0, 8'hA0);
        s0[1] = beat(0, 0, 8'hA1);
        s0[2] = beat(0, 1, 8'hA2);
        ex[2] = xp(2'b00, 1, 1, 0, 2'b01, 8'hA0);
        ex[3] = xp(2'b00, 1, 0, 0, 2'b01, 8'hA1);
        ex[4] = xp(2'b00, 1, 0, 1, 2'b01, 8'hA2);
        for (int c = 0; c < 6; c++) begin
            apply(s0[c], '0, 1'b1, 2'b00);
            @(negedge clk);
            checks++;
            if (obs() !== ex[c]) begin
                failures++;
                $display("FAIL t1_single_pkt cyc%0d: got %h required %h", c, obs(), ex[c]);
            end
            step();
        end
    endtask

    task automatic test_simultaneous();
        logic [10:0] s0 [8] = '{default: '0};
        logic [10:0] s1 [8] = '{default: '0};
        logic [14:0] ex [8] = '{default: '0};
        reset = 1'b1;
        apply('0, '0, 1'b1, 2'b00);
        step();
        reset = 1'b0;
        s0[0] = beat(1, 0, 8'hB0);
        s0[1] = beat(0, 1, 8'hB1);
        s1[0] = beat(1, 0, 8'hC0);
        s1[1] = beat(0, 1, 8'hC1);
        ex[2] = xp(2'b00, 1, 1, 0, 2'b01, 8'hB0);
        ex[3] = xp(2'b00, 1, 0, 1, 2'b01, 8'hB1);
        ex[5] = xp(2'b00, 1, 1, 0, 2'b10, 8'hC0);
        ex[6] = xp(2'b00, 1, 0, 1, 2'b10, 8'hC1);
        for (int c = 0; c < 8; c++) begin
            apply(s0[c], s1[c], 1'b1, 2'b00);
            @(negedge clk);
            checks++;
            if (obs() !== ex[c]) begin
                failures++;
                $display("FAIL t2_round_robin cyc%0d: got %h required %h", c, obs(), ex[c]);
            end
            step();
        end
    endtask

    task automatic test_overflow();
        logic [10:0] s0  [17] = '{default: '0};
        logic        rdy [17] = '{default: 1'b1};
        logic [1:0]  clr [17] = '{default: '0};
        logic [14:0] ex  [17] = '{default: '0};
        for (int c = 0; c < 6; c++) s0[c] = beat(c == 0, c == 5, 8'hD0 + 8'(c));
        for (int c = 0; c < 8; c++) rdy[c] = 1'b0;
        for (int c = 2; c < 5; c++) ex[c] = xp(2'b00, 1, 1, 0, 2'b01, 8'hD0);
        for (int c = 5; c < 9; c++) ex[c] = xp(2'b01, 1, 1, 0, 2'b01, 8'hD0);
        ex[9]   = xp(2'b01, 1, 0, 0, 2'b01, 8'hD1);
        ex[10]  = xp(2'b01, 1, 0, 0, 2'b01, 8'hD2);
        ex[11]  = xp(2'b01, 1, 0, 0, 2'b01, 8'hD3);
        ex[12]  = xp(2'b01, 0, 0, 0, 2'b01, 8'h00);
        ex[13]  = xp(2'b01, 0, 0, 0, 2'b01, 8'h00);
        clr[13] = 2'b01;
        ex[14]  = xp(2'b00, 0, 0, 0, 2'b01, 8'h00);
        s0[14]  = beat(0, 1, 8'hD6);
        ex[15]  = xp(2'b00, 1, 0, 1, 2'b01, 8'hD6);
        for (int c = 0; c < 17; c++) begin
            apply(s0[c], '0, rdy[c], clr[c]);
            @(negedge clk);
            checks++;
            if (obs() !== ex[c]) begin
                failures++;
                $display("FAIL t3_overflow cyc%0d: got %h required %h", c, obs(), ex[c]);
            end
            step();
        end
    endtask

    task automatic test_full_pop_write();
        logic [10:0] s0  [12] = '{default: '0};
        logic        rdy [12] = '{default: 1'b1};
        logic [1:0]  clr [12] = '{default: '0};
        logic [14:0] ex  [12] = '{default: '0};
        for (int c = 0; c < 6; c++) s0[c] = beat(c == 0, c == 4, 8'hE0 + 8'(c));
        rdy[0] = 1'b0; rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b0; rdy[5] = 1'b0;
        for (int c = 2; c < 5; c++) ex[c] = xp(2'b00, 1, 1, 0, 2'b01, 8'hE0);
        ex[5]   = xp(2'b00, 1, 0, 0, 2'b01, 8'hE1);
        ex[6]   = xp(2'b01, 1, 0, 0, 2'b01, 8'hE1);
        ex[7]   = xp(2'b01, 1, 0, 0, 2'b01, 8'hE2);
        ex[8]   = xp(2'b01, 1, 0, 0, 2'b01, 8'hE3);
        ex[9]   = xp(2'b01, 1, 0, 1, 2'b01, 8'hE4);
        ex[10]  = xp(2'b01, 0, 0, 0, 2'b00, 8'h00);
        clr[10] = 2'b01;
        for (int c = 0; c < 12; c++) begin
            apply(s0[c], '0, rdy[c], clr[c]);
            @(negedge clk);
            checks++;
            if (obs() !== ex[c]) begin
                failures++;
                $display("FAIL t4_full_pop_write cyc%0d: got %h required %h", c, obs(), ex[c]);
            end
            step();
        end
    endtask

    task automatic test_orphan();
        logic [10:0] s1 [6] = '{default: '0};
        logic [14:0] ex [6] = '{default: '0};
        s1[0] = beat(0, 0, 8'h5F);
        s1[1] = beat(1, 0, 8'h60);
        s1[2] = beat(0, 1, 8'h61);
        ex[3] = xp(2'b00, 1, 1, 0, 2'b10, 8'h60);
        ex[4] = xp(2'b00, 1, 0, 1, 2'b10, 8'h61);
        for (int c = 0; c < 6; c++) begin
            apply('0, s1[c], 1'b1, 2'b00);
            @(negedge clk);
            checks++;
            if (obs() !== ex[c]) begin
                failures++;
                $display("FAIL t5_orphan cyc%0d: got %h required %h", c, obs(), ex[c]);
            end
            step();
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [10:0] s0  [8] = '{default: '0};
        logic [1:0]  clr [8] = '{default: '0};
        logic [14:0] ex  [8] = '{default: '0};
        logic [10:0] k0  [6] = '{default: '0};
        logic [14:0] kx  [6] = '{default: '0};
        for (int c = 0; c < 5; c++) s0[c] = beat(c == 0, 0, 8'h10 + 8'(c));
        s0[6]  = beat(0, 0, 8'h15);
        clr[4] = 2'b01;
        clr[5] = 2'b01;
        for (int c = 2; c < 5; c++) ex[c] = xp(2'b00, 1, 1, 0, 2'b01, 8'h10);
        ex[5]  = xp(2'b01, 1, 1, 0, 2'b01, 8'h10);
        ex[6]  = xp(2'b00, 1, 1, 0, 2'b01, 8'h10);
        ex[7]  = xp(2'b01, 1, 1, 0, 2'b01, 8'h10);
        for (int c = 0; c < 8; c++) begin
            apply(s0[c], '0, 1'b0, clr[c]);
            @(negedge clk);
            checks++;
            if (obs() !== ex[c]) begin
                failures++;
                $display("FAIL t6_ovf_set_clr cyc%0d: got %h required %h", c, obs(), ex[c]);
            end
            step();
        end
        reset = 1'b1;
        apply('0, '0, 1'b1, 2'b00);
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 15'h0) begin
            failures++;
            $display("FAIL t6_reset_mid_pkt: got %h required %h", obs(), 15'h0);
        end
        step();
        k0[2] = beat(1, 1, 8'h77);
        kx[4] = xp(2'b00, 1, 1, 1, 2'b01, 8'h77);
        for (int c = 0; c < 6; c++) begin
            apply(k0[c], '0, 1'b1, 2'b00);
            @(negedge clk);
            checks++;
            if (obs() !== kx[c]) begin
                failures++;
                $display("FAIL t6_after_reset cyc%0d: got %h required %h", c, obs(), kx[c]);
            end
            step();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        apply('0, '0, 1'b1, 2'b00);
        test_reset();
        test_simultaneous();
        test_overflow();
        test_full_pop_write();
        test_orphan();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
